// File: rtl/popcount27_patgen.sv
// Burst pattern generator for popcount27 circuits: each request yields 27 beats of a
// rotating thermometer code, each paired with its exact popcount as the golden weight.
module popcount27_patgen #(
   parameter int ROT_STEP = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_weight,
   output logic        pat_valid,
   input  logic        pat_ready,
   output logic [26:0] pat_data,
   output logic [4:0]  pat_weight,
   output logic        pat_last,
   output logic        err,
   output logic        o_dbg_emit
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // pat_valid never drops and the pattern never changes until that transfer completes.

   typedef enum logic {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

   localparam int unsigned RS       = ROT_STEP % 27;
   localparam logic [4:0]  LAST_IDX = 5'd26;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_req_ready;
   logic        r_err;
   logic [26:0] r_data;
   logic [4:0]  r_weight;
   logic [4:0]  r_idx;

   logic        w_accept;
   logic        w_legal;
   logic        w_fire;
   logic        w_at_last;
   logic [26:0] w_therm;
   logic [26:0] w_rot;

   assign w_accept  = req_valid & r_req_ready;
   assign w_legal   = (req_weight <= 5'd27);
   assign w_fire    = pat_valid & pat_ready;
   assign w_at_last = (r_idx == LAST_IDX);

   // Weight 27 would overflow the 27-bit shift, so it is special-cased to all ones.
   assign w_therm = (req_weight == 5'd27) ? '1 : ((27'd1 << req_weight) - 27'd1);
   assign w_rot   = (r_data << RS) | (r_data >> (27 - RS));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept && w_legal)  w_state_nxt = S_EMIT;
         S_EMIT:  if (w_fire && w_at_last)  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      pat_valid  = (r_state == S_EMIT);
      pat_last   = (r_state == S_EMIT) && w_at_last;
      o_dbg_emit = (r_state == S_EMIT);
   end

   // req_ready is registered from the next state, so it only rises once a burst has ended.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_ready <= 1'b0;
         r_err       <= 1'b0;
         r_data      <= '0;
         r_weight    <= '0;
         r_idx       <= '0;
      end else begin
         r_req_ready <= (w_state_nxt == S_IDLE);
         r_err       <= w_accept & ~w_legal;
         if (w_accept && w_legal) begin
            r_data   <= w_therm;
            r_weight <= req_weight;
            r_idx    <= '0;
         end else if (w_fire && !w_at_last) begin
            r_data <= w_rot;
            r_idx  <= r_idx + 5'd1;
         end
      end
   end

   assign req_ready  = r_req_ready;
   assign err        = r_err;
   assign pat_data   = r_data;
   assign pat_weight = r_weight;

endmodule
